// File: rtl/sata_link_layer_read.sv
// SATA link layer, receive side: accepts a FIS from the remote transmitter,
// descrambles it, withholds the trailing CRC dword, checks it and reports
// R_OK / R_ERR.
// Handshake: read_strobe marks read_data valid for exactly one cycle.
// read_ready low asks the remote end to pause (HOLD). Dwords still in flight
// are delivered, and only HOLDA-qualified dwords are dropped.
module sata_link_layer_read #(
    parameter int MAX_DWORDS = 2049
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phy_ready,
    input  logic        en,
    input  logic        is_device,
    input  logic        data_scrambler_en,
    input  logic        send_sync_escape,
    input  logic        detect_align,
    input  logic        detect_sync,
    input  logic        detect_x_rdy,
    input  logic        detect_sof,
    input  logic        detect_eof,
    input  logic        detect_wtrm,
    input  logic        detect_cont,
    input  logic        detect_hold,
    input  logic        detect_holda,
    input  logic [31:0] rx_din,
    input  logic [3:0]  rx_isk,
    input  logic        read_ready,
    output logic [31:0] tx_dout,
    output logic        tx_isk,
    output logic        read_strobe,
    output logic [31:0] read_data,
    output logic        read_finished,
    output logic        crc_ok,
    output logic        overflow_error,
    output logic        idle,
    output logic [3:0]  state
);

    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] PRIM_R_RDY = 32'h4A4A_957C;
    localparam logic [31:0] PRIM_R_IP  = 32'h5555_B57C;
    localparam logic [31:0] PRIM_HOLD  = 32'hD5D5_AA7C;
    localparam logic [31:0] PRIM_HOLDA = 32'h9595_AA7C;
    localparam logic [31:0] PRIM_R_OK  = 32'h3535_B57C;
    localparam logic [31:0] PRIM_R_ERR = 32'h5656_B57C;
    localparam logic [15:0] SCR_SEED   = 16'hF0F6;
    localparam logic [31:0] CRC_INIT   = 32'h5232_5032;
    localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
    localparam logic [12:0] MAX_CNT    = 13'(MAX_DWORDS);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        READ_START  = 4'd1,
        READ        = 4'd2,
        READ_END    = 4'd3,
        SEND_STATUS = 4'd4
    } state_t;

    // Scrambler LFSR x^16+x^15+x^13+x^4+1; returns {next_state, 32-bit mask}.
    function automatic logic [47:0] scr_step(input logic [15:0] s_in);
        logic [15:0] s;
        logic [31:0] o;
        s = s_in;
        o = '0;
        for (int i = 0; i < 32; i++) begin
            o = {s[15], o[31:1]};
            s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
        end
        return {s, o};
    endfunction

    // CRC-32 (0x04C11DB7), MSB first, one dword per call.
    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] c;
        logic [31:0] d;
        c = c_in;
        d = d_in;
        for (int i = 0; i < 32; i++) begin
            c = (c[31] ^ d[31]) ? ({c[30:0], 1'b0} ^ CRC_POLY) : {c[30:0], 1'b0};
            d = {d[30:0], 1'b0};
        end
        return c;
    endfunction

    state_t      r_state, w_next_state;
    logic [31:0] r_tx_dout, w_tx_prim;
    logic [15:0] r_scr;
    logic [31:0] r_crc, r_held, r_read_data, w_descr;
    logic [47:0] w_scr;
    logic [12:0] r_count;
    logic        r_held_valid, r_cont_active, r_hold_tail, r_crc_ok;
    logic        r_read_strobe, r_read_finished, r_overflow;
    logic        w_abort, w_any_prim, w_data_valid, w_eof, w_sof, w_overflow;
    logic        w_unused_role;

    // The device/host role does not change how a frame is received.
    assign w_unused_role = is_device;

    assign w_abort    = send_sync_escape || (r_state == READ && detect_sync);
    assign w_any_prim = phy_ready && !detect_cont &&
                        (rx_isk != 4'b0 || detect_align || detect_sync || detect_x_rdy ||
                         detect_sof || detect_eof || detect_wtrm || detect_hold || detect_holda);
    assign w_data_valid = r_state == READ && phy_ready && rx_isk == 4'b0 && !detect_align &&
                          !detect_cont && !r_cont_active && !detect_eof &&
                          !(!read_ready && detect_holda) && !w_abort;
    assign w_eof      = r_state == READ && detect_eof && !w_abort;
    assign w_sof      = r_state == READ_START && detect_sof && !send_sync_escape;
    assign w_overflow = w_data_valid && r_count == MAX_CNT;
    assign w_scr      = scr_step(r_scr);
    assign w_descr    = data_scrambler_en ? (rx_din ^ w_scr[31:0]) : rx_din;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next state and the primitive to transmit.
    always_comb begin
        w_next_state = r_state;
        w_tx_prim    = PRIM_SYNC;
        case (r_state)
            IDLE: begin
                if (en && detect_x_rdy) w_next_state = READ_START;
            end
            READ_START: begin
                w_tx_prim = PRIM_R_RDY;
                if (detect_sof)       w_next_state = READ;
                else if (detect_sync) w_next_state = IDLE;
            end
            READ: begin
                if (!read_ready)                     w_tx_prim = PRIM_HOLD;
                else if (detect_hold || r_hold_tail) w_tx_prim = PRIM_HOLDA;
                else                                 w_tx_prim = PRIM_R_IP;
                if (w_overflow) w_next_state = SEND_STATUS;
                else if (w_eof) w_next_state = READ_END;
            end
            READ_END: begin
                w_tx_prim    = PRIM_R_IP;
                w_next_state = SEND_STATUS;
            end
            SEND_STATUS: begin
                w_tx_prim = r_crc_ok ? PRIM_R_OK : PRIM_R_ERR;
                if (detect_sync) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        if (w_abort) begin
            w_next_state = IDLE;
            w_tx_prim    = PRIM_SYNC;
        end
    end

    // Datapath: tx register, descramble, one-dword holdback, CRC and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_dout       <= PRIM_SYNC;
            r_scr           <= SCR_SEED;
            r_crc           <= CRC_INIT;
            r_held          <= '0;
            r_held_valid    <= 1'b0;
            r_cont_active   <= 1'b0;
            r_hold_tail     <= 1'b0;
            r_count         <= '0;
            r_crc_ok        <= 1'b0;
            r_read_strobe   <= 1'b0;
            r_read_data     <= '0;
            r_read_finished <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            r_read_strobe   <= 1'b0;
            r_read_finished <= 1'b0;
            r_overflow      <= 1'b0;
            if (phy_ready) r_tx_dout <= w_tx_prim;
            r_hold_tail <= (r_state == READ) && detect_hold && !w_abort;
            if (w_abort) begin
                r_count       <= '0;
                r_held        <= '0;
                r_held_valid  <= 1'b0;
                r_cont_active <= 1'b0;
            end else if (w_sof) begin
                r_scr         <= SCR_SEED;
                r_crc         <= CRC_INIT;
                r_count       <= '0;
                r_held_valid  <= 1'b0;
                r_cont_active <= 1'b0;
                r_crc_ok      <= 1'b0;
            end else if (r_state == READ) begin
                if (phy_ready && detect_cont) r_cont_active <= 1'b1;
                else if (w_any_prim)          r_cont_active <= 1'b0;
                if (w_overflow) begin
                    r_overflow <= 1'b1;
                    r_crc_ok   <= 1'b0;
                end else if (w_data_valid) begin
                    r_count      <= r_count + 13'd1;
                    r_scr        <= w_scr[47:32];
                    r_held       <= w_descr;
                    r_held_valid <= 1'b1;
                    if (r_held_valid) begin
                        r_read_strobe <= 1'b1;
                        r_read_data   <= r_held;
                        r_crc         <= crc_step(r_crc, r_held);
                    end
                end else if (w_eof) begin
                    r_read_finished <= 1'b1;
                    r_crc_ok        <= r_held_valid && (r_held == r_crc);
                    r_held_valid    <= 1'b0;
                end
            end
        end
    end

    assign tx_dout        = r_tx_dout;
    assign tx_isk         = 1'b1;
    assign read_strobe    = r_read_strobe;
    assign read_data      = r_read_data;
    assign read_finished  = r_read_finished;
    assign crc_ok         = r_crc_ok;
    assign overflow_error = r_overflow;
    assign idle           = (r_state == IDLE);
    assign state          = r_state;

endmodule

// File: tb/tb_sata_link_layer_read.sv
// Bench for sata_link_layer_read: table of whole frames plus hand-written
// hold, remote-hold/CONT, overflow and sync-escape sequences.
module tb_sata_link_layer_read;

  localparam logic [31:0] SYNC  = 32'hB5B5_957C;
  localparam logic [31:0] R_RDY = 32'h4A4A_957C;
  localparam logic [31:0] R_IP  = 32'h5555_B57C;
  localparam logic [31:0] HOLD  = 32'hD5D5_AA7C;
  localparam logic [31:0] HOLDA = 32'h9595_AA7C;
  localparam logic [31:0] R_OK  = 32'h3535_B57C;
  localparam logic [31:0] R_ERR = 32'h5656_B57C;

  localparam int P_NONE = 0, P_ALIGN = 1, P_SYNC = 2, P_XRDY = 3, P_SOF = 4;
  localparam int P_EOF = 5, P_WTRM = 6, P_CONT = 7, P_HOLD = 8, P_HOLDA = 9;

  logic clk = 1'b0, rst = 1'b1;
  logic phy_ready = 1'b1, en = 1'b1, is_device = 1'b0, data_scrambler_en = 1'b1;
  logic send_sync_escape = 1'b0;
  logic detect_align = 0, detect_sync = 0, detect_x_rdy = 0, detect_sof = 0, detect_eof = 0;
  logic detect_wtrm = 0, detect_cont = 0, detect_hold = 0, detect_holda = 0;
  logic [31:0] rx_din = '0;
  logic [3:0]  rx_isk = 4'b0001;
  logic        read_ready = 1'b1;
  logic [31:0] tx_dout, read_data;
  logic        tx_isk, read_strobe, read_finished, crc_ok, overflow_error, idle;
  logic [3:0]  state;

  sata_link_layer_read #(.MAX_DWORDS(8)) dut (
    .clk(clk), .rst(rst), .phy_ready(phy_ready), .en(en), .is_device(is_device),
    .data_scrambler_en(data_scrambler_en), .send_sync_escape(send_sync_escape),
    .detect_align(detect_align), .detect_sync(detect_sync), .detect_x_rdy(detect_x_rdy),
    .detect_sof(detect_sof), .detect_eof(detect_eof), .detect_wtrm(detect_wtrm),
    .detect_cont(detect_cont), .detect_hold(detect_hold), .detect_holda(detect_holda),
    .rx_din(rx_din), .rx_isk(rx_isk), .read_ready(read_ready),
    .tx_dout(tx_dout), .tx_isk(tx_isk), .read_strobe(read_strobe), .read_data(read_data),
    .read_finished(read_finished), .crc_ok(crc_ok), .overflow_error(overflow_error),
    .idle(idle), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [31:0] exp_q[$];
  int n_checks = 0, n_pass = 0;
  int strobe_cnt = 0, fin_cnt = 0, ovf_cnt = 0;
  logic fin_crc_ok = 1'b0;
  logic [15:0] m_scr;
  logic [31:0] m_crc;

  typedef struct {
    int          n;
    logic        incr;
    logic [31:0] flip;
    logic        scr_en;
    logic        no_crc;
    logic        exp_ok;
    logic [31:0] exp_status;
  } frame_t;
  frame_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // reference scrambler: 16-bit LFSR, taps 16,15,13,4, LSB of dword first
  task automatic m_scramble(output logic [31:0] w);
    w = '0;
    for (int b = 0; b < 32; b++) begin
      w = {m_scr[15], w[31:1]};
      m_scr = {m_scr[14:0], ^(m_scr & 16'hD008)};
    end
  endtask

  task automatic m_crc_add(input logic [31:0] p);
    logic [31:0] d;
    d = p;
    for (int b = 0; b < 32; b++) begin
      m_crc = {m_crc[30:0], 1'b0} ^ ((m_crc[31] ^ d[31]) ? 32'h04C1_1DB7 : 32'h0);
      d = d << 1;
    end
  endtask

  // monitor, run once per cycle at the falling edge before new inputs
  task automatic sample();
    if (read_strobe) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: read_data=%h, no dword expected", read_data);
      end else begin
        check("read_data", read_data, exp_q.pop_front());
      end
    end
    if (read_finished) begin
      fin_cnt++;
      fin_crc_ok = crc_ok;
    end
    if (overflow_error) ovf_cnt++;
  endtask

  // driver tasks
  task automatic drive(input logic [31:0] din, input logic [3:0] isk, input int p,
                       input logic rr, input logic esc);
    @(negedge clk);
    sample();
    rx_din = din; rx_isk = isk; read_ready = rr; send_sync_escape = esc;
    detect_align = (p == P_ALIGN); detect_sync = (p == P_SYNC); detect_x_rdy = (p == P_XRDY);
    detect_sof = (p == P_SOF); detect_eof = (p == P_EOF); detect_wtrm = (p == P_WTRM);
    detect_cont = (p == P_CONT); detect_hold = (p == P_HOLD); detect_holda = (p == P_HOLDA);
  endtask

  task automatic prim(input int p);
    drive(32'h0000_007C, 4'b0001, p, 1'b1, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] payload, input logic push);
    logic [31:0] s;
    m_scramble(s);
    m_crc_add(payload);
    if (push) exp_q.push_back(payload);
    drive(data_scrambler_en ? (payload ^ s) : payload, 4'b0000, P_NONE, 1'b1, 1'b0);
  endtask

  task automatic send_crc(input logic [31:0] flip);
    logic [31:0] s;
    m_scramble(s);
    drive(data_scrambler_en ? (m_crc ^ flip ^ s) : (m_crc ^ flip), 4'b0000, P_NONE, 1'b1, 1'b0);
  endtask

  task automatic start_frame();
    strobe_cnt = 0; fin_cnt = 0; ovf_cnt = 0;
    prim(P_XRDY);
    prim(P_XRDY);
    check("state_read_start", {28'h0, state}, 32'd1);
    prim(P_SOF);
    check("tx_r_rdy", tx_dout, R_RDY);
    m_scr = 16'hF0F6;
    m_crc = 32'h5232_5032;
  endtask

  task automatic end_frame(input logic exp_ok, input logic [31:0] exp_status, input int exp_n);
    prim(P_EOF);
    prim(P_WTRM);
    prim(P_WTRM);
    prim(P_WTRM);
    check("tx_status", tx_dout, exp_status);
    check("finished_pulses", fin_cnt, 32'd1);
    check("crc_ok", {31'h0, fin_crc_ok}, {31'h0, exp_ok});
    check("strobe_count", strobe_cnt, exp_n);
    check("queue_empty", exp_q.size(), 32'd0);
    check("no_overflow", ovf_cnt, 32'd0);
    prim(P_SYNC);
    prim(P_NONE);
    check("idle_after_sync", {31'h0, idle}, 32'd1);
  endtask

  task automatic run_frame(input frame_t f);
    data_scrambler_en = f.scr_en;
    start_frame();
    for (int i = 0; i < f.n; i++) send_word(f.incr ? 32'(i + 1) : $urandom, 1'b1);
    if (!f.no_crc) send_crc(f.flip);
    end_frame(f.exp_ok, f.exp_status, f.n);
  endtask

  initial begin
    //           n  incr flip   scr  nocrc ok  status
    tbl[0] = '{4, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, R_OK};
    tbl[1] = '{4, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0, R_ERR};
    tbl[2] = '{3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, R_OK};
    tbl[3] = '{0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, R_OK};
    tbl[4] = '{0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, R_ERR};
    tbl[5] = '{7, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, R_OK};

    // reset values
    repeat (3) @(negedge clk);
    check("rst_tx_dout", tx_dout, SYNC);
    check("rst_tx_isk", {31'h0, tx_isk}, 32'd1);
    check("rst_idle", {31'h0, idle}, 32'd1);
    check("rst_state", {28'h0, state}, 32'd0);
    check("rst_strobe", {31'h0, read_strobe}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_finished", {31'h0, read_finished}, 32'd0);
    check("rst_crc_ok", {31'h0, crc_ok}, 32'd0);
    check("rst_overflow", {31'h0, overflow_error}, 32'd0);
    rst = 1'b0;
    prim(P_NONE);
    prim(P_NONE);
    check("idle_tx_sync", tx_dout, SYNC);

    for (int t = 0; t < 6; t++) run_frame(tbl[t]);
    data_scrambler_en = 1'b1;

    // local flow control: read_ready low 5 cycles, HOLDA returned
    start_frame();
    send_word($urandom, 1'b1);
    send_word($urandom, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) drive($urandom, 4'b0000, P_HOLDA, 1'b0, 1'b0);
      else        drive(32'h0000_007C, 4'b0001, P_HOLDA, 1'b0, 1'b0);
      if (k == 1) check("tx_hold", tx_dout, HOLD);
    end
    send_word($urandom, 1'b1);
    send_word($urandom, 1'b1);
    check("tx_r_ip_resume", tx_dout, R_IP);
    send_crc(32'h0);
    end_frame(1'b1, R_OK, 4);

    // remote HOLD, CONT and two junk dwords
    start_frame();
    send_word($urandom, 1'b1);
    send_word($urandom, 1'b1);
    prim(P_HOLD);
    prim(P_HOLD);
    check("tx_holda", tx_dout, HOLDA);
    prim(P_CONT);
    drive($urandom, 4'b0000, P_NONE, 1'b1, 1'b0);
    check("tx_holda_tail", tx_dout, HOLDA);
    drive($urandom, 4'b0000, P_NONE, 1'b1, 1'b0);
    check("tx_r_ip_after_tail", tx_dout, R_IP);
    prim(P_HOLD);
    send_word($urandom, 1'b1);
    send_word($urandom, 1'b1);
    send_crc(32'h0);
    end_frame(1'b1, R_OK, 4);

    // overflow: 10 data dwords into MAX_DWORDS=8
    start_frame();
    for (int i = 0; i < 10; i++) send_word(32'(i + 1), i < 7);
    prim(P_NONE);
    check("overflow_pulses", ovf_cnt, 32'd1);
    check("overflow_tx_r_err", tx_dout, R_ERR);
    check("overflow_strobes", strobe_cnt, 32'd7);
    check("overflow_queue_empty", exp_q.size(), 32'd0);
    check("overflow_no_finished", fin_cnt, 32'd0);
    prim(P_SYNC);
    prim(P_NONE);
    check("overflow_idle", {31'h0, idle}, 32'd1);

    // sync escape after two dwords, then a clean frame
    start_frame();
    send_word($urandom, 1'b1);
    send_word($urandom, 1'b0);
    drive(32'h0000_007C, 4'b0001, P_NONE, 1'b1, 1'b1);
    prim(P_NONE);
    check("escape_idle", {31'h0, idle}, 32'd1);
    check("escape_tx_sync", tx_dout, SYNC);
    prim(P_NONE);
    prim(P_NONE);
    check("escape_no_finished", fin_cnt, 32'd0);
    check("escape_strobes", strobe_cnt, 32'd1);
    check("escape_queue_empty", exp_q.size(), 32'd0);
    run_frame(tbl[0]);
    check("tx_isk_const", {31'h0, tx_isk}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sata_link_layer_read.md
SATA_LINK_LAYER_READ -- requirements
Module: sata_link_layer_read

Interface
REQ-001 Parameter MAX_DWORDS, 2049, maximum FIS data dwords plus CRC accepted per frame.
REQ-002 Ports SHALL be exactly those listed in REQ-003 to REQ-015; one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  link clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 phy_ready  in  1  PHY can accept a tx dword this cycle; rx dword valid.
REQ-006 en / is_device / data_scrambler_en  in  1 each  enable; role (1 = device); descrambling enable.
REQ-007 send_sync_escape  in  1  abort the current frame.
REQ-008 detect_align, detect_sync, detect_x_rdy, detect_sof, detect_eof, detect_wtrm, detect_cont, detect_hold, detect_holda  in  1 each  decoded rx primitives.
REQ-009 rx_din  in  32  rx dword; rx_isk  in  4  K-char flags.
REQ-010 read_ready  in  1  transport can accept data.
REQ-011 tx_dout  out  32  tx dword; tx_isk  out  1  tx_dout is a primitive.
REQ-012 read_strobe  out  1  read_data valid; read_data  out  32  descrambled payload dword.
REQ-013 read_finished  out  1  one-cycle end-of-frame pulse; crc_ok  out  1  valid with read_finished.
REQ-014 overflow_error  out  1  one-cycle pulse when the frame exceeds MAX_DWORDS.
REQ-015 idle  out  1  state == IDLE; state  out  4  FSM state, for debug.

Function
REQ-016 FSM states: IDLE=0, READ_START=1, READ=2, READ_END=3, SEND_STATUS=4.
REQ-017 IDLE: transmit PRIM_SYNC; go to READ_START when en && detect_x_rdy.
REQ-018 READ_START: transmit PRIM_R_RDY; detect_sof -> READ; detect_sync -> IDLE.
REQ-019 READ: transmit PRIM_R_IP by default. A dword is data only when rx_isk==0, phy_ready==1, detect_align==0 and no CONT is active.
REQ-020 CONT: detect_cont sets cont_active; any subsequent primitive clears it. Data-class dwords received while cont_active SHALL be discarded.
REQ-021 Descramble: descramble each data dword with the codebase scrambler, reset at SOF; bypass when data_scrambler_en==0. Feed the descrambled dwords to the codebase crc module, reset at SOF.
REQ-022 One-dword holdback: each descrambled dword is held until the next data dword arrives. The next data dword releases it to read_data with read_strobe one cycle later, so no dword is released before it is known not to be the CRC.
REQ-023 EOF: on detect_eof in READ, the held dword is the CRC and SHALL NOT be strobed. Compare it against the crc output over the delivered dwords, then -> READ_END.
REQ-024 Flow control: when read_ready==0 in READ, transmit PRIM_HOLD; discard incoming data only while detect_holda; resume PRIM_R_IP the cycle after read_ready returns.
REQ-025 Remote hold: when detect_hold in READ, transmit PRIM_HOLDA; PRIM_HOLDA is continued for 1 cycle after detect_hold falls.
REQ-026 read_ready==0 takes priority over detect_hold (PRIM_HOLD is sent).
REQ-027 READ_END: transmit PRIM_R_IP for one cycle, then -> SEND_STATUS; pulse read_finished with crc_ok.
REQ-028 SEND_STATUS: transmit PRIM_R_OK if crc_ok, else PRIM_R_ERR, until detect_sync -> IDLE.
REQ-029 Counter: 13-bit dword counter cleared at SOF and incremented per accepted data dword. If it reaches MAX_DWORDS+1, pulse overflow_error, set crc_ok=0, go to SEND_STATUS.
REQ-030 Frame too short: EOF with no held dword -> crc_ok=0.
REQ-031 tx_isk=1 for every primitive; this block never transmits data.
REQ-032 tx_dout changes only when phy_ready==1; otherwise the previous dword is held.
REQ-033 send_sync_escape overrides everything: -> IDLE next cycle, transmit PRIM_SYNC, clear counter, holdback register and cont_active, no read_finished pulse.
REQ-034 Simultaneous events: detect_eof together with a data dword treats the dword as invalid; detect_sync in READ aborts like REQ-033.

Reset
REQ-035 On rst: state=IDLE, tx_dout=PRIM_SYNC, tx_isk=1, read_strobe=0, read_data=0, read_finished=0, crc_ok=0, overflow_error=0, idle=1, counter=0, cont_active=0.
REQ-036 On rst release, the block SHALL wait for the next X_RDY; reset mid-frame SHALL drop the frame silently.

Verification
REQ-037 X_RDY, SOF, 4 scrambled dwords of 0x00000001..0x00000004, valid CRC, EOF, WTRM, SYNC -> exactly 4 read_strobe with descrambled data 1..4, R_OK, crc_ok=1.
REQ-038 Same frame with CRC bit 0 flipped -> 4 strobes, crc_ok=0, R_ERR until SYNC.
REQ-039 read_ready low for 5 cycles mid-frame with HOLDA returned -> HOLD sent, no data lost or duplicated, R_IP resumes, R_OK at end.
REQ-040 Remote HOLD for 3 cycles plus CONT plus 2 junk dwords mid-frame -> HOLDA sent, junk discarded, strobe count unchanged, R_OK.
REQ-041 MAX_DWORDS=8, send 10 dwords -> overflow_error pulse on the 9th accepted dword, R_ERR.
REQ-042 send_sync_escape after 2 dwords -> SYNC next cycle, idle=1, no read_finished; the next frame is received correctly.
